// File: rtl/dcache_mon_pkg.sv
// dcache_mon_pkg: shared error/flush enums and default sizing for the dcache port monitor.
package dcache_mon_pkg;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_OVERFLOW    = 3'd1,
        ERR_SPURIOUS    = 3'd2,
        ERR_TIMEOUT     = 3'd3,
        ERR_REQ_DROP    = 3'd4,
        ERR_FLUSH_PROTO = 3'd5
    } err_code_e;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_WAIT  = 2'd1,
        F_ACKED = 2'd2
    } flush_state_e;

    localparam int unsigned DEF_NR_PORTS        = 3;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;
    localparam int unsigned DEF_TS_WIDTH        = 16;
    localparam int unsigned DEF_CNT_WIDTH       = 32;
    localparam int unsigned DEF_TIMEOUT         = 1024;

endpackage

// File: rtl/dcache_port_monitor_if.sv
// dcache_port_monitor_if: core<->dcache req/gnt/rvalid and flush handshake bundle.
interface dcache_port_monitor_if
    import dcache_mon_pkg::*;
#(
    parameter int unsigned NR_PORTS = DEF_NR_PORTS
) ();
    logic [NR_PORTS-1:0] req_valid;
    logic [NR_PORTS-1:0] req_we;
    logic [NR_PORTS-1:0] gnt;
    logic [NR_PORTS-1:0] rvalid;
    logic                flush;
    logic                flush_ack;

    modport master (output req_valid, req_we, gnt, rvalid, flush, flush_ack);
    modport slave  (input  req_valid, req_we, gnt, rvalid, flush, flush_ack);
endinterface

// File: rtl/dcache_mon_ts_fifo.sv
// dcache_mon_ts_fifo: per-port FIFO of grant timestamps; push while full is accepted only with a pop.
module dcache_mon_ts_fifo
    import dcache_mon_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_MAX_OUTSTANDING,
    parameter int unsigned W     = DEF_TS_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 data_i,
    output logic [W-1:0]                 head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign do_pop  = pop_i & ~empty_o;
    // When full, the slot being written is the head being popped this cycle.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= data_i;
            rd_q  <= rd_q + AW'(do_pop);
            wr_q  <= wr_q + AW'(do_push);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/dcache_port_monitor.sv
// dcache_port_monitor: passive dcache port/flush protocol monitor with latency and error tracking.
// Define DCACHE_PORT_MONITOR_ASSERT_EN to also report every error event with $error.
module dcache_port_monitor
    import dcache_mon_pkg::*;
#(
    parameter int unsigned NR_PORTS        = DEF_NR_PORTS,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned TS_WIDTH        = DEF_TS_WIDTH,
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int unsigned TIMEOUT         = DEF_TIMEOUT
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    dcache_port_monitor_if.slave                             bus,
    input  logic                                             err_clr_i,
    output logic [NR_PORTS*$clog2(MAX_OUTSTANDING+1)-1:0]    outstanding_o,
    output logic [CNT_WIDTH-1:0]                             rd_cnt_o,
    output logic [CNT_WIDTH-1:0]                             wr_cnt_o,
    output logic [TS_WIDTH-1:0]                              max_lat_o,
    output logic                                             err_o,
    output logic [2:0]                                       err_code_o,
    output logic [$clog2(NR_PORTS)-1:0]                      err_port_o
);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING+1);
    localparam int unsigned PW = $clog2(NR_PORTS);
    localparam int unsigned SW = CNT_WIDTH + 1;

    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] head [NR_PORTS];
    logic [TS_WIDTH-1:0] age  [NR_PORTS];
    logic [NR_PORTS-1:0] ld, st, pop, full, empty;
    logic [NR_PORTS-1:0] ovf, spur, tmo, drop;
    logic [NR_PORTS-1:0] to_flag_q, to_flag_d, req_q, gnt_q;
    flush_state_e        fstate_q, fstate_d;
    logic                ack_q, flush_err;
    logic                ev_any;
    err_code_e           ev_code, err_code_q, err_code_d;
    logic [PW-1:0]       ev_port, err_port_q, err_port_d;
    logic                err_q, err_d;
    logic [SW-1:0]       rd_sum, wr_sum;
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [TS_WIDTH-1:0] max_lat_q, max_lat_d;

    assign ld = bus.req_valid & bus.gnt & ~bus.req_we;
    assign st = bus.req_valid & bus.gnt &  bus.req_we;

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
        dcache_mon_ts_fifo #(.DEPTH(MAX_OUTSTANDING), .W(TS_WIDTH)) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (ld[p]),
            .pop_i   (bus.rvalid[p]),
            .data_i  (ts_q),
            .head_o  (head[p]),
            .full_o  (full[p]),
            .empty_o (empty[p]),
            .count_o (outstanding_o[p*CW +: CW])
        );
        assign age[p]  = ts_q - head[p];
        assign pop[p]  = bus.rvalid[p] & ~empty[p];
        assign ovf[p]  = ld[p] & full[p] & ~pop[p];
        assign spur[p] = bus.rvalid[p] & empty[p];
        // Reported once per head entry; the flag re-arms when the head leaves.
        assign tmo[p]  = ~empty[p] & ~to_flag_q[p] & (age[p] > TS_WIDTH'(TIMEOUT));
        assign drop[p] = req_q[p] & ~gnt_q[p] & ~bus.req_valid[p];
    end

    assign to_flag_d = (to_flag_q | tmo) & ~pop;

    always_comb begin
        flush_err = (bus.flush_ack & ((fstate_q == F_IDLE) | ack_q)) | ((fstate_q == F_WAIT) & ~bus.flush);
        fstate_d  = fstate_q == F_IDLE ? (bus.flush ? F_WAIT : F_IDLE)
                  : fstate_q == F_WAIT ? (!bus.flush ? F_IDLE : bus.flush_ack ? F_ACKED : F_WAIT)
                  : (bus.flush ? F_ACKED : F_IDLE);
    end

    // Later assignments override earlier ones: lowest code, then lowest port, wins.
    always_comb begin
        ev_any  = |{ovf, spur, tmo, drop, flush_err};
        ev_code = flush_err ? ERR_FLUSH_PROTO : ERR_NONE;
        ev_port = '0;
        for (int p = NR_PORTS-1; p >= 0; p--) if (drop[p]) begin ev_code = ERR_REQ_DROP; ev_port = PW'(p); end
        for (int p = NR_PORTS-1; p >= 0; p--) if (tmo[p])  begin ev_code = ERR_TIMEOUT;  ev_port = PW'(p); end
        for (int p = NR_PORTS-1; p >= 0; p--) if (spur[p]) begin ev_code = ERR_SPURIOUS; ev_port = PW'(p); end
        for (int p = NR_PORTS-1; p >= 0; p--) if (ovf[p])  begin ev_code = ERR_OVERFLOW; ev_port = PW'(p); end
        err_d      = err_clr_i ? 1'b0 : err_q | ev_any;
        err_code_d = err_clr_i ? ERR_NONE : (!err_q && ev_any) ? ev_code : err_code_q;
        err_port_d = err_clr_i ? '0 : (!err_q && ev_any) ? ev_port : err_port_q;
    end

    always_comb begin
        rd_sum    = {1'b0, rd_cnt_q};
        wr_sum    = {1'b0, wr_cnt_q};
        max_lat_d = max_lat_q;
        for (int p = 0; p < NR_PORTS; p++) begin
            rd_sum = rd_sum + SW'(ld[p]);
            wr_sum = wr_sum + SW'(st[p]);
            if (pop[p] && age[p] > max_lat_d) max_lat_d = age[p];
        end
        rd_cnt_d = rd_sum[CNT_WIDTH] ? '1 : rd_sum[CNT_WIDTH-1:0];
        wr_cnt_d = wr_sum[CNT_WIDTH] ? '1 : wr_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q       <= '0;
            to_flag_q  <= '0;
            req_q      <= '0;
            gnt_q      <= '0;
            fstate_q   <= F_IDLE;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_port_q <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            max_lat_q  <= '0;
        end else begin
            ts_q       <= ts_q + 1'b1;
            to_flag_q  <= to_flag_d;
            req_q      <= bus.req_valid;
            gnt_q      <= bus.gnt;
            fstate_q   <= fstate_d;
            ack_q      <= bus.flush_ack;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_port_q <= err_port_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            max_lat_q  <= max_lat_d;
        end
    end

    assign rd_cnt_o   = rd_cnt_q;
    assign wr_cnt_o   = wr_cnt_q;
    assign max_lat_o  = max_lat_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign err_port_o = err_port_q;

`ifdef DCACHE_PORT_MONITOR_ASSERT_EN
    always @(posedge clk_i) begin
        if (rst_ni) begin
            for (int p = 0; p < NR_PORTS; p++) begin
                assert (!ovf[p])  else $error("dcache_port_monitor: code 1 port %0d ts %0d", p, ts_q);
                assert (!spur[p]) else $error("dcache_port_monitor: code 2 port %0d ts %0d", p, ts_q);
                assert (!tmo[p])  else $error("dcache_port_monitor: code 3 port %0d ts %0d", p, ts_q);
                assert (!drop[p]) else $error("dcache_port_monitor: code 4 port %0d ts %0d", p, ts_q);
            end
            assert (!flush_err) else $error("dcache_port_monitor: code 5 port 0 ts %0d", ts_q);
        end
    end
`endif
endmodule

// File: tb/tb_dcache_port_monitor.sv
// tb_dcache_port_monitor: scoreboard bench for dcache_port_monitor (NR_PORTS=3, depth 4, TIMEOUT=100).
module tb_dcache_port_monitor;
    import dcache_mon_pkg::*;

    localparam int NP = 3;
    localparam int MO = 4;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_clr = 1'b0;
    logic [8:0]  outstanding;
    logic [31:0] rd_cnt, wr_cnt;
    logic [15:0] max_lat;
    logic        err;
    logic [2:0]  err_code;
    logic [1:0]  err_port;

    dcache_port_monitor_if #(.NR_PORTS(NP)) bus ();

    dcache_port_monitor #(.NR_PORTS(NP), .MAX_OUTSTANDING(MO), .TS_WIDTH(16), .CNT_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus),
        .err_clr_i     (err_clr),
        .outstanding_o (outstanding),
        .rd_cnt_o      (rd_cnt),
        .wr_cnt_o      (wr_cnt),
        .max_lat_o     (max_lat),
        .err_o         (err),
        .err_code_o    (err_code),
        .err_port_o    (err_port)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int ts_m = 0, rd_m = 0, wr_m = 0, max_m = 0;
    int mq [NP][$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_err(input string tag, input logic e, input logic [2:0] code, input logic [1:0] port);
        check({tag, "_err"}, err, e);
        check({tag, "_code"}, err_code, code);
        check({tag, "_port"}, err_port, port);
    endtask

    // Drive one cycle, advance the scoreboard across the edge, compare after it.
    task automatic step(input logic [2:0] req, input logic [2:0] we, input logic [2:0] gnt,
                        input logic [2:0] rv, input logic fl, input logic ack, input logic clr);
        int pre, lat;
        logic popped;
        bus.req_valid = req; bus.req_we = we; bus.gnt = gnt; bus.rvalid = rv;
        bus.flush = fl; bus.flush_ack = ack; err_clr = clr;
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            pre = mq[p].size();
            popped = 1'b0;
            if (rv[p] && pre > 0) begin
                lat = ts_m - mq[p].pop_front();
                popped = 1'b1;
                if (lat > max_m) max_m = lat;
            end
            if (req[p] && gnt[p]) begin
                if (we[p]) wr_m++;
                else begin
                    rd_m++;
                    if (pre < MO || popped) mq[p].push_back(ts_m);
                end
            end
        end
        ts_m++;
        #1;
        for (int p = 0; p < NP; p++) check($sformatf("outstanding%0d", p), outstanding[p*3 +: 3], mq[p].size());
        check("rd_cnt", rd_cnt, rd_m);
        check("wr_cnt", wr_cnt, wr_m);
        check("max_lat", max_lat, max_m);
    endtask

    task automatic idle(input int n);
        repeat (n) step(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear();
        step(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1);
        chk_err("clr", 1'b0, 3'd0, 2'd0);
    endtask

    initial begin
        int k;
        bus.req_valid = '0; bus.req_we = '0; bus.gnt = '0; bus.rvalid = '0;
        bus.flush = 1'b0; bus.flush_ack = 1'b0;
        #12;
        check("rst_outstanding", outstanding, 0);
        check("rst_rd", rd_cnt, 0);
        check("rst_max", max_lat, 0);
        chk_err("rst", 1'b0, 3'd0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Port 1 in-order loads: grants at 10..12, responses at 15, 16, 20.
        idle(10);
        repeat (3) step(3'b010, 3'b000, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
        check("p1_peak", outstanding[5:3], 3);
        idle(2);
        repeat (2) step(3'b000, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0);
        idle(3);
        step(3'b000, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0);
        check("p1_max_lat", max_lat, 8);
        check("p1_rd", rd_cnt, 3);
        chk_err("p1", 1'b0, 3'd0, 2'd0);

        // Two stores granted in one cycle add two.
        step(3'b101, 3'b101, 3'b101, 3'b000, 1'b0, 1'b0, 1'b0);
        check("wr_popcount", wr_cnt, 2);

        // Port 0 overflow, then legal push+pop while full.
        repeat (4) step(3'b001, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
        step(3'b001, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
        chk_err("ovf", 1'b1, 3'd1, 2'd0);
        clear();
        step(3'b001, 3'b000, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0);
        chk_err("full_pushpop", 1'b0, 3'd0, 2'd0);
        check("full_count", outstanding[2:0], 4);
        repeat (4) step(3'b000, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0);

        // Spurious response, then clear; clear beats a same-cycle error.
        step(3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0);
        chk_err("spur", 1'b1, 3'd2, 2'd2);
        clear();
        step(3'b000, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1);
        chk_err("clr_wins", 1'b0, 3'd0, 2'd0);

        // Request withdrawn without a grant.
        step(3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        step(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
        chk_err("req_drop", 1'b1, 3'd4, 2'd1);
        clear();

        // Timeout: flag must rise exactly TO+1 edges after the grant edge.
        step(3'b001, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
        chk_err("to_pre", 1'b0, 3'd0, 2'd0);
        k = 0;
        while (!err && k < 200) begin
            idle(1);
            k++;
        end
        check("to_cycles", k, TO + 1);
        chk_err("to", 1'b1, 3'd3, 2'd0);
        clear();
        idle(5);
        chk_err("to_once", 1'b0, 3'd0, 2'd0);
        step(3'b000, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0);
        check("to_late_lat", max_lat >= 16'(TO + 1), 1);

        // Port 2 overflow and port 0 spurious together: lower code wins.
        repeat (4) step(3'b100, 3'b000, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0);
        step(3'b100, 3'b000, 3'b100, 3'b001, 1'b0, 1'b0, 1'b0);
        chk_err("prio", 1'b1, 3'd1, 2'd2);
        clear();
        repeat (4) step(3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 1'b0);

        // Flush: two-cycle ack is illegal.
        step(3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        step(3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        chk_err("flush_ack1", 1'b0, 3'd0, 2'd0);
        step(3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        chk_err("flush_ack2", 1'b1, 3'd5, 2'd0);
        idle(1);
        clear();
        // Legal flush, then an ack in idle proves the FSM went back to F_IDLE.
        step(3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        step(3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0);
        step(3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk_err("flush_legal", 1'b0, 3'd0, 2'd0);
        step(3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
        chk_err("flush_idle_ack", 1'b1, 3'd5, 2'd0);
        clear();
        // Flush dropped while waiting for the ack.
        step(3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk_err("flush_drop", 1'b1, 3'd5, 2'd0);
        clear();

        // Asynchronous reset in the middle of traffic.
        step(3'b010, 3'b000, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
        step(3'b000, 3'b000, 3'b000, 3'b100, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_outstanding", outstanding, 0);
        check("mid_rst_rd", rd_cnt, 0);
        check("mid_rst_wr", wr_cnt, 0);
        check("mid_rst_max", max_lat, 0);
        chk_err("mid_rst", 1'b0, 3'd0, 2'd0);
        for (int p = 0; p < NP; p++) mq[p].delete();
        rd_m = 0; wr_m = 0; max_m = 0;
        bus.rvalid = '0; bus.req_valid = '0; bus.gnt = '0; bus.flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ts_m = 0;
        step(3'b010, 3'b000, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
        idle(2);
        step(3'b000, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0);
        check("post_rst_lat", max_lat, 3);
        chk_err("post_rst", 1'b0, 3'd0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
